// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU decoder and the M-extension unit.
`timescale 1ns/1ps
package alu_pkg;

  // 4-bit ALU control codes driven to the execute-stage ALU.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_BNE  = 4'b1011;
  localparam logic [3:0] ALU_BLT  = 4'b1100;
  localparam logic [3:0] ALU_BGE  = 4'b1101;
  localparam logic [3:0] ALU_BLTU = 4'b1110;
  localparam logic [3:0] ALU_BGEU = 4'b1111;
  localparam logic [3:0] ALU_AUX  = 4'b1111;

  // M-extension operations, encoded exactly as funct3.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_S_MUL = 2'b01,
    MDU_S_DIV = 2'b10,
    MDU_DONE = 2'b11
  } mdu_state_e;

  function automatic logic mdu_is_div(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic mdu_is_signed_div(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_REM};
  endfunction

  function automatic logic mdu_wants_rem(input mdu_op_e op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle.
// The quotient/remainder outputs show the result of the step being taken
// this cycle, so they are final in the cycle where done is high.
`timescale 1ns/1ps
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  // One restoring step: shift in the next dividend bit, keep the trial
  // subtraction only when it does not go negative.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, div_q};
    rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_next = {quo_q[XLEN-2:0], ~diff[XLEN]};
  end

  assign busy      = (count != '0);
  assign done      = (count == CW'(1));
  assign quotient  = quo_next;
  assign remainder = rem_next;

  // Iteration registers: load on start, step while busy, drop on abort.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      count <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else if (abort) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(XLEN);
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
    end else if (busy) begin
      count <= count - CW'(1);
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

endmodule

// File: rtl/mdu_exec_ctrl.sv
// Execute-stage ALU control decoder with an RV32M multiply/divide unit.
// Base ops decode combinationally; M ops run a 2-cycle multiply or an
// iterative divide and stall the pipeline until the result is ready.
`timescale 1ns/1ps
module mdu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [1:0]      alu_op_i,
  input  logic            op5_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic [3:0]      alu_ctrl_o,
  output logic            is_mdu_o,
  output logic            stall_o,
  output logic            mdu_valid_o,
  output logic [XLEN-1:0] mdu_result_o
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  mdu_state_e      state;
  mdu_op_e         op_in;
  mdu_op_e         op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic            q_neg_q;
  logic            r_neg_q;

  logic            is_mdu;
  logic            alt_sel;
  logic            accept;
  logic            div_by_zero;
  logic            div_ovf;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] dividend_abs;
  logic [XLEN-1:0] divisor_abs;
  logic [XLEN-1:0] special_res;
  logic            div_start;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] div_res;

  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_res;

  assign is_mdu   = ENABLE_M && (alu_op_i == 2'b10) && op5_i && (funct7_i == 7'b0000001);
  assign is_mdu_o = is_mdu;
  assign op_in    = mdu_op_e'(funct3_i);
  assign alt_sel  = op5_i & funct7_i[5];

  // Base ALU control decode; M ops present ADD to the ALU.
  always_comb begin
    // NOTE: the default assignment first guarantees every path drives the
    // output, so no latch is inferred for unlisted cases.
    alu_ctrl_o = ALU_ADD;
    if (!is_mdu) begin
      unique case (alu_op_i)
        2'b00: alu_ctrl_o = ALU_ADD;
        2'b01: begin
          unique case (funct3_i)
            3'b000:  alu_ctrl_o = ALU_BEQ;
            3'b001:  alu_ctrl_o = ALU_BNE;
            3'b100:  alu_ctrl_o = ALU_BLT;
            3'b101:  alu_ctrl_o = ALU_BGE;
            3'b110:  alu_ctrl_o = ALU_BLTU;
            3'b111:  alu_ctrl_o = ALU_BGEU;
            default: alu_ctrl_o = ALU_ADD;
          endcase
        end
        2'b10: begin
          unique case (funct3_i)
            3'b000:  alu_ctrl_o = alt_sel ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl_o = ALU_SLL;
            3'b010:  alu_ctrl_o = ALU_SLT;
            3'b011:  alu_ctrl_o = ALU_SLTU;
            3'b100:  alu_ctrl_o = ALU_XOR;
            3'b101:  alu_ctrl_o = alt_sel ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl_o = ALU_OR;
            default: alu_ctrl_o = ALU_AND;
          endcase
        end
        default: alu_ctrl_o = ALU_AUX;
      endcase
    end
  end

  // Divide setup from the live operands: special cases, magnitudes, signs.
  always_comb begin
    div_by_zero  = (b_i == '0);
    div_ovf      = mdu_is_signed_div(op_in) && (a_i == MOST_NEG) && (b_i == ALL_ONES);
    a_neg        = mdu_is_signed_div(op_in) & a_i[XLEN-1];
    b_neg        = mdu_is_signed_div(op_in) & b_i[XLEN-1];
    dividend_abs = a_neg ? -a_i : a_i;
    divisor_abs  = b_neg ? -b_i : b_i;
    if (div_by_zero) special_res = mdu_wants_rem(op_in) ? a_i : ALL_ONES;
    else             special_res = mdu_wants_rem(op_in) ? '0  : a_i;
  end

  assign accept    = (state == MDU_IDLE) && valid_i && is_mdu && !flush_i;
  assign div_start = accept && mdu_is_div(op_in) && !div_by_zero && !div_ovf;
  assign stall_o   = valid_i && is_mdu && (state != MDU_DONE);

  // Full-width product from latched operands, extended per signedness.
  always_comb begin
    a_ext   = (op_q == MDU_MULH || op_q == MDU_MULHSU) ?
              {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
    b_ext   = (op_q == MDU_MULH) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    product = a_ext * b_ext;
    mul_res = (op_q == MDU_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // Sign fix of the final divider step: quotient follows sign difference,
  // remainder follows the dividend.
  always_comb begin
    if (mdu_wants_rem(op_q)) div_res = r_neg_q ? -div_rem : div_rem;
    else                     div_res = q_neg_q ? -div_quo : div_quo;
  end

  mdu_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush_i),
    .dividend  (dividend_abs),
    .divisor   (divisor_abs),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sequencing FSM with registered result and valid pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so the result bus is a
      // defined zero after reset rather than whatever powered up.
      state        <= MDU_IDLE;
      op_q         <= MDU_MUL;
      a_q          <= '0;
      b_q          <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      mdu_valid_o  <= 1'b0;
      mdu_result_o <= '0;
    end else begin
      mdu_valid_o <= 1'b0;
      if (flush_i) begin
        state <= MDU_IDLE;
      end else begin
        unique case (state)
          MDU_IDLE: begin
            if (accept) begin
              op_q    <= op_in;
              a_q     <= a_i;
              b_q     <= b_i;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              if (!mdu_is_div(op_in)) begin
                state <= MDU_S_MUL;
              end else if (div_by_zero || div_ovf) begin
                mdu_result_o <= special_res;
                mdu_valid_o  <= 1'b1;
                state        <= MDU_DONE;
              end else begin
                state <= MDU_S_DIV;
              end
            end
          end
          MDU_S_MUL: begin
            mdu_result_o <= mul_res;
            mdu_valid_o  <= 1'b1;
            state        <= MDU_DONE;
          end
          MDU_S_DIV: begin
            if (div_done) begin
              mdu_result_o <= div_res;
              mdu_valid_o  <= 1'b1;
              state        <= MDU_DONE;
            end else if (!div_busy) begin
              state <= MDU_IDLE;
            end
          end
          default: state <= MDU_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_exec_ctrl.sv
// Directed self-checking bench for mdu_exec_ctrl (with and without M support).
`timescale 1ns/1ps
module tb_mdu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [1:0]  alu_op_i;
  logic        op5_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;

  logic [3:0]  alu_ctrl_o, alu_ctrl_nm;
  logic        is_mdu_o, is_mdu_nm;
  logic        stall_o, stall_nm;
  logic        mdu_valid_o, mdu_valid_nm;
  logic [31:0] mdu_result_o, mdu_result_nm;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_exec_ctrl #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_op_i(alu_op_i), .op5_i(op5_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .alu_ctrl_o(alu_ctrl_o), .is_mdu_o(is_mdu_o), .stall_o(stall_o),
    .mdu_valid_o(mdu_valid_o), .mdu_result_o(mdu_result_o)
  );

  mdu_exec_ctrl #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_op_i(alu_op_i), .op5_i(op5_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .alu_ctrl_o(alu_ctrl_nm), .is_mdu_o(is_mdu_nm), .stall_o(stall_nm),
    .mdu_valid_o(mdu_valid_nm), .mdu_result_o(mdu_result_nm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    valid_i  = 1'b0;
    alu_op_i = 2'b00;
    op5_i    = 1'b0;
    funct3_i = 3'b000;
    funct7_i = 7'b0000000;
    a_i      = '0;
    b_i      = '0;
  endtask

  task automatic set_base(input logic [1:0] aop, input logic o5, input logic [2:0] f3,
                          input logic [6:0] f7);
    valid_i  = 1'b1;
    alu_op_i = aop;
    op5_i    = o5;
    funct3_i = f3;
    funct7_i = f7;
  endtask

  task automatic set_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    set_base(2'b10, 1'b1, f3, 7'b0000001);
    a_i = a;
    b_i = b;
  endtask

  // Issue one M op, count stall cycles, check the DONE cycle and the hold after.
  task automatic run_mdu(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int n;
    n = 0;
    set_m(f3, a, b);
    #1;
    while (stall_o === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check({tag, " stall_cycles"}, n, exp_stall);
    check({tag, " valid"}, {31'd0, mdu_valid_o}, 32'd1);
    check({tag, " result"}, mdu_result_o, exp);
    set_idle();
    tick();
    check({tag, " valid_after"}, {31'd0, mdu_valid_o}, 32'd0);
    check({tag, " result_hold"}, mdu_result_o, exp);
  endtask

  // Expect no valid pulse for n cycles.
  task automatic quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    repeat (n) begin
      tick();
      if (mdu_valid_o === 1'b1) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    flush_i = 1'b0;
    set_idle();
    repeat (3) tick();
    check("reset result", mdu_result_o, 32'd0);
    check("reset valid", {31'd0, mdu_valid_o}, 32'd0);
    check("reset stall", {31'd0, stall_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Base decode, combinational.
    set_base(2'b10, 1'b1, 3'b101, 7'b0100000); #1;
    check("sra ctrl", {28'd0, alu_ctrl_o}, 32'h7);
    check("sra stall", {31'd0, stall_o}, 32'd0);
    set_base(2'b10, 1'b0, 3'b101, 7'b0000000); #1;
    check("srl ctrl", {28'd0, alu_ctrl_o}, 32'h6);
    set_base(2'b10, 1'b1, 3'b000, 7'b0100000); #1;
    check("sub ctrl", {28'd0, alu_ctrl_o}, 32'h1);
    set_base(2'b10, 1'b0, 3'b000, 7'b0100000); #1;
    check("addi ctrl", {28'd0, alu_ctrl_o}, 32'h0);
    set_base(2'b10, 1'b1, 3'b111, 7'b0000000); #1;
    check("and ctrl", {28'd0, alu_ctrl_o}, 32'h4);
    set_base(2'b10, 1'b1, 3'b011, 7'b0000000); #1;
    check("sltu ctrl", {28'd0, alu_ctrl_o}, 32'h9);
    set_base(2'b00, 1'b1, 3'b111, 7'b0100000); #1;
    check("aluop00 ctrl", {28'd0, alu_ctrl_o}, 32'h0);
    set_base(2'b01, 1'b0, 3'b001, 7'b0000001); #1;
    check("bne ctrl", {28'd0, alu_ctrl_o}, 32'hB);
    check("branch not mdu", {31'd0, is_mdu_o}, 32'd0);
    set_base(2'b01, 1'b0, 3'b010, 7'b0000000); #1;
    check("branch f3_010 ctrl", {28'd0, alu_ctrl_o}, 32'h0);
    set_base(2'b11, 1'b0, 3'b000, 7'b0000000); #1;
    check("aluop11 ctrl", {28'd0, alu_ctrl_o}, 32'hF);
    set_m(3'b001, 32'd5, 32'd6); #1;
    check("m op is_mdu", {31'd0, is_mdu_o}, 32'd1);
    check("m op ctrl", {28'd0, alu_ctrl_o}, 32'h0);
    set_m(3'b000, 32'd5, 32'd6); #1;
    check("nm is_mdu", {31'd0, is_mdu_nm}, 32'd0);
    check("nm ctrl", {28'd0, alu_ctrl_nm}, 32'h0);
    check("nm stall", {31'd0, stall_nm}, 32'd0);
    set_idle();
    tick();

    // Multiply.
    run_mdu("mulh -1*-1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2);
    run_mdu("mulhu max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    run_mdu("mul -1*-1",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 2);
    run_mdu("mulhsu -1*max",3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);

    // Divide.
    run_mdu("div -7/2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_mdu("rem -7%2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_mdu("div 7/-2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_mdu("rem 7%-2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
    run_mdu("divu 100/7",   3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_mdu("remu 100%7",   3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_mdu("div minneg/2", 3'b100, 32'h80000000, 32'd2,        32'hC0000000, 33);
    run_mdu("divu min/max", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    run_mdu("remu min/max", 3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);

    // Divide special cases.
    run_mdu("divu 5/0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_mdu("remu 5/0",     3'b111, 32'd5,        32'd0,        32'd5,        1);
    run_mdu("div ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_mdu("rem ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_mdu("mul 3*4",      3'b000, 32'd3,        32'd4,        32'd12,       2);

    // Flush at DIV cycle 10.
    set_m(3'b100, 32'hFFFFFFF9, 32'd2);
    tick();
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    set_idle();
    #1;
    check("flush valid", {31'd0, mdu_valid_o}, 32'd0);
    check("flush result", mdu_result_o, 32'd12);
    quiet("flush no pulse", 40);
    check("flush result later", mdu_result_o, 32'd12);
    run_mdu("mul after flush", 3'b000, 32'd6, 32'd7, 32'd42, 2);

    // Flush in IDLE blocks a new M op.
    set_m(3'b101, 32'd100, 32'd7);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    set_idle();
    quiet("idle flush no start", 40);
    check("idle flush result", mdu_result_o, 32'd42);

    // valid_i drops mid-divide: stall releases at once, op still completes.
    set_m(3'b101, 32'd100, 32'd7);
    repeat (3) tick();
    set_idle();
    #1;
    check("vdrop stall", {31'd0, stall_o}, 32'd0);
    n = 0;
    while (mdu_valid_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("vdrop valid", {31'd0, mdu_valid_o}, 32'd1);
    check("vdrop result", mdu_result_o, 32'd14);
    tick();

    // Reset mid-divide.
    set_m(3'b100, 32'hFFFFFFF9, 32'd2);
    repeat (6) tick();
    rst_n = 1'b0;
    set_idle();
    tick();
    check("midrst result", mdu_result_o, 32'd0);
    check("midrst valid", {31'd0, mdu_valid_o}, 32'd0);
    check("midrst stall", {31'd0, stall_o}, 32'd0);
    rst_n = 1'b1;
    quiet("midrst no pulse", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_exec_ctrl.md
# mdu_exec_ctrl

Parametrised successor to the single-cycle ALU decoder, adding RV32M support. Decodes ALUOp/opcode/funct fields into the existing 4-bit ALU control code for base instructions. For M-extension ops it runs a 2-cycle multiplier or an iterative divider and stalls the pipeline until the result is ready. Sits in the execute stage beside the ALU; its result feeds the writeback mux through `is_mdu_o`.

## Interface
- `XLEN`, 32: operand/result width.
- `ENABLE_M`, 1: when 0, M-encodings decode as base ALU ops; MDU never starts.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `valid_i` in 1: instruction in execute is valid.
- `alu_op_i` in 2: ALUOp from main decoder.
- `op5_i` in 1: opcode bit 5 (1 = R-type).
- `funct3_i` in 3: funct3.
- `funct7_i` in 7: funct7.
- `a_i`, `b_i` in XLEN: rs1/rs2 operands.
- `flush_i` in 1: abort the in-flight MDU op.
- `alu_ctrl_o` out 4: ALU control code.
- `is_mdu_o` out 1: current instruction is an M op.
- `stall_o` out 1: hold PC and upstream registers.
- `mdu_valid_o` out 1: result valid this cycle.
- `mdu_result_o` out XLEN: MDU result.

## Operation
- **M op detect:** `ENABLE_M & alu_op_i==2'b10 & op5_i & funct7_i==7'b0000001`. `is_mdu_o` is this combinationally, independent of `valid_i`.
- **Base decode (combinational), ALUOp 00:** ADD (0000).
- **Base decode, ALUOp 01:** funct3 000/001/100/101/110/111 → 1010/1011/1100/1101/1110/1111; other funct3 → 0000.
- **Base decode, ALUOp 10:** funct3 000 → SUB 0001 if `op5_i & funct7_i[5]`, else ADD 0000. 001 SLL 0101; 010 SLT 1000; 011 SLTU 1001; 100 XOR 0010; 101 → SRA 0111 if `op5_i & funct7_i[5]`, else SRL 0110; 110 OR 0011; 111 AND 0100.
- **Base decode, ALUOp 11:** 1111.
- **M ops:** `alu_ctrl_o` = 0000.
- **MDU ops by funct3:** 000 MUL (low), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- **FSM states:** IDLE, MUL, DIV, DONE.
  - IDLE: on `valid_i & is_mdu` latch operands and op. Multiplies → MUL. Divide by zero or signed overflow → DONE with special result. Other divides → DIV: load |a|,|b| for signed ops, count = XLEN.
  - MUL: compute 2·XLEN product with sign extension per op, register selected half → DONE.
  - DIV: restoring divide, one quotient bit per cycle, count-1. At count==1 apply sign fix → DONE. Quotient negated if operand signs differ; remainder takes the dividend sign.
  - DONE: `mdu_valid_o`=1 → IDLE.
- **Divide by zero:** quotient all-ones, remainder = a.
- **Signed overflow** (a = most-negative, b = −1): quotient = a, remainder = 0.
- **`stall_o`:** `valid_i & is_mdu & state!=DONE`. Low in DONE, so the pipeline advances at the end of DONE.
- **Back-to-back M ops:** the next op starts in IDLE the following cycle.
- **`flush_i`:** any state → IDLE next cycle. No `mdu_valid_o` pulse; `mdu_result_o` unchanged. Flush in IDLE with a new M op: the op does not start.
- **Reset:** state IDLE, count 0, `mdu_result_o` 0, `mdu_valid_o` 0, `stall_o` 0.

## Timing
- Base ops: zero latency, combinational.
- Multiply: 3 cycles of occupancy (IDLE, MUL, DONE). Stall high for 2 cycles; result in cycle 2.
- Divide: XLEN+2 cycles (IDLE, XLEN×DIV, DONE). Stall high for XLEN+1 cycles.
- Divide special cases: 2 cycles (IDLE, DONE).
- `mdu_result_o` is registered and holds until the next completion.
- `valid_i` dropping mid-op: the op completes; `stall_o` goes low immediately.

## Structure
- **Package `alu_pkg`:** ALU control code localparams (4-bit), `mdu_op_e` (8 ops), `mdu_state_e`.
- **Sub-module `mdu_divider`:** iterative restoring divider with start/busy/done, parametrised by XLEN, holding count, remainder and quotient registers. Multiply and FSM live in the top module.

## Test plan
- ALUOp 10, funct3 101, op5 1, funct7 0100000 → `alu_ctrl_o` 0111. Same with op5 0, funct7 0000000 → 0110. `stall_o` 0.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → stall 2 cycles, result 0x00000000. MULHU same operands → 0xFFFFFFFE. MUL → 0x00000001.
- DIV a=−7, b=2 → stall 33 cycles, quotient 0xFFFFFFFD. REM → 0xFFFFFFFF.
- DIVU a=5, b=0 → 2-cycle op, 0xFFFFFFFF. REM a=0x80000000, b=−1 → 0.
- `flush_i` at DIV cycle 10 → IDLE next cycle, no `mdu_valid_o`, result unchanged. `rst_n`=0 mid-DIV → all outputs 0 next cycle.
- ENABLE_M=0, MUL encoding → `is_mdu_o` 0, `alu_ctrl_o` 0000, no stall.
